mux_nx1_pipe: RTL and testbench
===============================

Name: mux_nx1_pipe

Overview:
Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It is the pipelined successor to the combinational 3:1 32-bit datapath mux. Two select modes are supported:
- Fixed: external sel picks the channel.
- Round-robin: the block arbitrates among valid channels.

It is used wherever the datapath needs a registered source select between producer stages.

Parameters:
WIDTH, 32, data width per channel (>=1)
N, 3, number of input channels (2..16)
SEL_W, 2, select/source-index width; requires 2**SEL_W >= N

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset; synchronous, active-low
in_data  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready (combinational)
sel  input  SEL_W  channel index used in fixed mode
mode  input  1  0 = fixed select, 1 = round-robin
out_data  output  WIDTH  registered selected data
out_src  output  SEL_W  index of channel that produced out_data
out_valid  output  1  output register holds a word
out_ready  input  1  downstream accepts

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at rising edge): out_valid=0, out_data=0, out_src=0, rr_ptr=N-1 so channel 0 has first priority.
- Reset mid-transfer: a held word is discarded with no completion. in_ready is forced to 0 while rst_n=0.
- can_load = !out_valid || out_ready. The output register is a single stage, so full throughput is one word per cycle.
- Chosen channel (combinational, same cycle):
  - mode=0: chosen = sel if sel < N and in_valid[sel]=1; otherwise none.
  - mode=0, sel >= N: no channel is chosen, all in_ready=0, and nothing is accepted.
  - mode=1: first i with in_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... and wrapping modulo N. If no in_valid is set, none.
- in_ready[i] = can_load && (i == chosen). At most one in_ready bit is high. in_ready never depends on in_valid of other channels in mode 0.
- Transfer: in_valid[i] && in_ready[i] at an edge.
  - out_data <= channel i data; out_src <= i; out_valid <= 1.
  - mode=1 only: rr_ptr <= i.
- Latency: an accepted word appears on out_data/out_valid the cycle after acceptance.
- Output drain: out_valid && out_ready with no new transfer -> out_valid <= 0. out_data and out_src hold their last value.
- Back-pressure: while out_valid && !out_ready, out_data, out_src and out_valid are stable and all in_ready=0.
- Simultaneous drain and load: when out_ready=1 and a channel transfers in the same cycle, the new word replaces the old one and out_valid stays 1 with no bubble.
- Mode or sel changes take effect combinationally on the next arbitration. They never alter a word already held.
- rr_ptr is unchanged in mode 0. On return to mode 1, the search resumes from the stored rr_ptr.

Optional Feature:
MUX_NX1_PIPE_XFER_CNT_EN
- Defined: adds output port xfer_cnt [15:0].
  - Increments by 1 on each output transfer (out_valid && out_ready).
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
(All cases use WIDTH=32, N=3, channel data a=32'h0, b=32'h1, c=32'h2.)
1. Reset: hold rst_n=0 two cycles with all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=3'b000.
2. Fixed mode: mode=0, out_ready=1, all valid; sel=0,1,2 on successive cycles -> out_data 0,1,2 and out_src 0,1,2, each one cycle after its select. Then sel=3 -> in_ready=000 and out_valid falls after a drain.
3. Round-robin: mode=1, all valid, out_ready=1 from reset -> out_src sequence 0,1,2,0,1,2 with out_valid continuously 1.
4. Round-robin skip: mode=1, in_valid=3'b101 -> out_src 0,2,0,2; channel 1 in_ready always 0.
5. Back-pressure: out_ready=0 after the first word (data 1 from sel=1) -> out_data=1 stable and in_ready=000 for 5 cycles. out_ready=1 -> the next word loads in the same cycle with no bubble.
6. Mid-operation reset: rst_n=0 for one cycle while out_valid=1 and out_ready=0 -> out_valid=0 next cycle. After rst_n=1 in mode 1, the first grant is channel 0 (with XFER_CNT_EN defined, xfer_cnt=0).

Source files
------------

// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N-input, WIDTH-bit registered multiplexer with valid/ready handshakes.
//
// The block selects one input channel per cycle and loads it into a single output register.
// It has two select modes:
//   mode=0 : fixed; the external sel picks the channel.
//   mode=1 : round-robin; the search starts one channel after the last grant and wraps.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous, active-low reset
//   in_data    N*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   sel        channel index used in fixed mode
//   mode       0 = fixed select, 1 = round-robin
//   out_data   registered selected data
//   out_src    index of the channel that produced out_data
//   out_valid  output register holds a word
//   out_ready  downstream accepts
//   xfer_cnt   saturating count of output transfers (only with MUX_NX1_PIPE_XFER_CNT_EN)
//
// Optional feature macro: MUX_NX1_PIPE_XFER_CNT_EN adds the xfer_cnt port and counter.

module mux_nx1_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_NX1_PIPE_XFER_CNT_EN
  ,
  output logic [15:0]        xfer_cnt
`endif
);

  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_src_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] rr_ptr_q;

  logic             can_load;
  logic             chosen_vld;
  logic [SEL_W-1:0] chosen_idx;
  logic [WIDTH-1:0] chosen_data;
  logic             xfer;

  assign can_load = !out_valid_q || out_ready;

  // Channel choice. In round-robin the offsets are scanned from far to near so the nearest
  // valid channel after rr_ptr is the last writer and wins.
  always_comb begin
    int unsigned idx;
    chosen_vld = 1'b0;
    chosen_idx = '0;
    idx        = 0;
    if (!mode) begin
      // sel >= N matches no channel, so nothing is chosen.
      for (int unsigned i = 0; i < N; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          chosen_vld = 1'b1;
          chosen_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned k = N; k >= 1; k--) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= N) idx = idx - N;
        for (int unsigned i = 0; i < N; i++) begin
          if (idx == i && in_valid[i]) begin
            chosen_vld = 1'b1;
            chosen_idx = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    chosen_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (chosen_idx == SEL_W'(i)) chosen_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // rst_n gates the grant so no channel sees a handshake while reset is asserted.
  assign xfer = rst_n && can_load && chosen_vld;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = xfer && (chosen_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      // Pointer at the last channel so channel 0 is searched first.
      rr_ptr_q    <= SEL_W'(N - 1);
    end else begin
      if (xfer) begin
        out_data_q  <= chosen_data;
        out_src_q   <= chosen_idx;
        out_valid_q <= 1'b1;
        if (mode) rr_ptr_q <= chosen_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

`ifdef MUX_NX1_PIPE_XFER_CNT_EN
  logic [15:0] xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else if (out_valid_q && out_ready && xfer_cnt_q != 16'hFFFF) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe (WIDTH=32, N=3). Channel data a=0, b=1, c=2.
// Inputs change 1 time unit after a rising edge; registered outputs are sampled there and
// in_ready is sampled one further unit later, after the new inputs have settled.

module tb_mux_nx1_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = 3;
  localparam int unsigned SEL_W = 2;

  logic               clk;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX_NX1_PIPE_XFER_CNT_EN
  logic [15:0]        xfer_cnt;
`endif

  int n_vec;
  int n_err;

  mux_nx1_pipe #(
    .WIDTH(WIDTH),
    .N    (N),
    .SEL_W(SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .out_data (out_data),
    .out_src  (out_src),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_NX1_PIPE_XFER_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] skip_src [4];
  logic [2:0] skip_rdy [4];

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 3'b111;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_data   = {32'h2, 32'h1, 32'h0};
    skip_src  = '{2'd0, 2'd2, 2'd0, 2'd2};
    skip_rdy  = '{3'b001, 3'b100, 3'b001, 3'b100};

    // Reset held two cycles with every channel valid.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_src", 32'(out_src), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
    end

    // Fixed mode, sel 0,1,2 then out-of-range 3.
    rst_n = 1'b1;
    mode  = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = SEL_W'(s);
      #1;
      check("fix_ready", 32'(in_ready), 32'(3'b001 << s));
      tick();
      check("fix_valid", 32'(out_valid), 32'd1);
      check("fix_src", 32'(out_src), 32'(s));
      check("fix_data", out_data, 32'(s));
    end
    sel = 2'd3;
    #1;
    check("fix_sel3_ready", 32'(in_ready), 32'd0);
    tick();
    check("fix_drain_valid", 32'(out_valid), 32'd0);
    check("fix_drain_data", out_data, 32'd2);
    check("fix_drain_src", 32'(out_src), 32'd2);

    // Round-robin from reset, all valid.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode  = 1'b1;
    sel   = 2'd0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(in_ready), 32'(3'b001 << (k % 3)));
      tick();
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_src", 32'(out_src), 32'(k % 3));
      check("rr_data", out_data, 32'(k % 3));
    end

    // Round-robin skipping channel 1.
    in_valid = 3'b101;
    for (int e = 0; e < 4; e++) begin
      #1;
      check("skip_ready", 32'(in_ready), 32'(skip_rdy[e]));
      tick();
      check("skip_src", 32'(out_src), 32'(skip_src[e]));
      check("skip_valid", 32'(out_valid), 32'd1);
    end

    // Back-pressure after a word from sel=1.
    in_valid  = 3'b111;
    mode      = 1'b0;
    sel       = 2'd1;
    out_ready = 1'b1;
    #1;
    check("bp_ready0", 32'(in_ready), 32'(3'b010));
    tick();
    check("bp_data0", out_data, 32'd1);
    check("bp_src0", 32'(out_src), 32'd1);
    out_ready = 1'b0;
    #1;
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_data", out_data, 32'd1);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    sel       = 2'd2;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'(3'b100));
    tick();
    check("bp_next_data", out_data, 32'd2);
    check("bp_next_src", 32'(out_src), 32'd2);
    check("bp_next_valid", 32'(out_valid), 32'd1);

    // Reset while a word is held under back-pressure.
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mrst_ready", 32'(in_ready), 32'd0);
    tick();
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_data", out_data, 32'd0);
    check("mrst_src", 32'(out_src), 32'd0);
`ifdef MUX_NX1_PIPE_XFER_CNT_EN
    check("mrst_cnt", 32'(xfer_cnt), 32'd0);
`endif
    rst_n     = 1'b1;
    mode      = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mrst_rr_ready", 32'(in_ready), 32'(3'b001));
    tick();
    check("mrst_rr_src", 32'(out_src), 32'd0);
    check("mrst_rr_valid", 32'(out_valid), 32'd1);
`ifdef MUX_NX1_PIPE_XFER_CNT_EN
    check("cnt_first", 32'(xfer_cnt), 32'd0);
`endif
    tick();
    check("mrst_rr_src2", 32'(out_src), 32'd1);
`ifdef MUX_NX1_PIPE_XFER_CNT_EN
    check("cnt_second", 32'(xfer_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
